exu_lsu_pipe: RTL and testbench
===============================

# exu_lsu_pipe

Parametrised, pipelined load/store unit for the execute stage. It is the successor to the single-transaction memory stage: it adds configurable data width, a configurable number of outstanding bus transactions and a registered issue stage. It also adds in-order response tracking, flush with kill of in-flight loads, and registered writeback. It sits between the execute/dispatch logic and the core data bus (req/gnt/rvalid protocol).

## Interface
- ADDR_W, 32, address width
- XLEN, 32, data/bus width; 32 or 64
- OUTSTANDING, 2, max granted-but-unanswered transactions; power of two, 1..8
- RD_W, 5, destination register index width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- req_valid_i / req_ready_o  in/out  1  request handshake; transfer when both high
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  XLEN  store data, LSB-aligned
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
- req_unsigned_i  in  1  zero-extend load
- req_rd_i  in  RD_W  load destination
- flush_i  in  1  kill ungranted request and in-flight loads
- bus_req_o  out  1  bus request
- bus_gnt_i  in  1  bus grant
- bus_addr_o  out  ADDR_W  address aligned to XLEN/8
- bus_we_o  out  1  write
- bus_be_o  out  XLEN/8  byte enables
- bus_wdata_o  out  XLEN  lane-shifted store data
- bus_rvalid_i  in  1  in-order response
- bus_rdata_i  in  XLEN  read data
- wb_valid_o  out  1  load writeback strobe (1 cycle)
- wb_rd_o  out  RD_W  writeback register
- wb_data_o  out  XLEN  formatted load data
- store_done_o  out  1  store response pulse
- misaligned_o  out  1  misaligned request pulse
- bad_addr_o  out  ADDR_W  address of the misaligned request
- spurious_o  out  1  rvalid with nothing pending
- busy_o  out  1  issue register valid or pending count > 0

## Operation
- **Offset and alignment.** off = addr[log2(XLEN/8)-1:0]. A request is misaligned if off mod 2^size != 0, or if size = 3 with XLEN = 32.
- **Misaligned request.**
  - Accepted (req_ready_o behaves normally) but not issued.
  - Next cycle: misaligned_o = 1 and bad_addr_o = addr.
- **Issue register.** Holds one aligned request. Contents: aligned addr, we, be = ((1<<2^size)-1) << off, wdata << 8*off, rd, size, off, unsigned.
- **bus_req_o** = issue_valid & (cnt < OUTSTANDING), where cnt is the number of granted, unanswered transactions. Bus fields are driven from the issue register and held stable until grant.
- **Grant** (bus_req_o & bus_gnt_i): push metadata {we, rd, size, off, unsigned, kill = 0} into the pending FIFO (depth OUTSTANDING) and clear or refill the issue register.
- **req_ready_o** = ~rst & (~issue_valid | (bus_req_o & bus_gnt_i)). This allows back-to-back issue at one request per cycle.
- **Response** (bus_rvalid_i):
  - Pop the FIFO head.
  - Load: rdata >> 8*off, truncate to 2^size bytes, then sign-extend (~unsigned) or zero-extend to XLEN. Register into wb_* with wb_valid_o = ~kill.
  - Store: store_done_o = 1 (kill is irrelevant).
- **flush_i:**
  - Drops an ungranted issue register. If a grant occurs in the same cycle, the grant wins: the entry is pushed with kill = 1.
  - Sets kill on every pending load.
  - A request presented with flush_i is not accepted (req_ready_o forced 0).
- **Simultaneous push and pop:** cnt is unchanged; the FIFO pointers wrap modulo OUTSTANDING.
- **Grant limit:** the cnt < OUTSTANDING check uses the pre-pop count. A pop in the same cycle does not enable a grant.
- **Spurious response:** rvalid with cnt == 0 gives spurious_o = 1 next cycle. Nothing else changes.

## Timing
- **Reset:** all registered outputs are 0 (wb_*, store_done_o, misaligned_o, bad_addr_o, spurious_o). bus_req_o = 0, busy_o = 0, req_ready_o = 0 while rst is high. The issue register, FIFO and cnt are cleared.
- **Reset mid-operation:** pending transactions are forgotten. A later rvalid reports spurious_o.
- **Latency:**
  - Accept at cycle N → bus_req_o at N+1.
  - Grant at G → rvalid legal from G+1, never in cycle G.
  - rvalid at R → wb_valid_o or store_done_o at R+1.
  - Minimum load-to-writeback with zero-wait grant and 1-cycle response: 3 cycles.
- **Throughput:** one transaction per cycle while cnt < OUTSTANDING.
- **Bus stability:** bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o hold while bus_req_o & ~bus_gnt_i.

## Test plan
- **LB sign extension:** XLEN=32 LB at 0x1003, rdata 0x80FF_0000 → wb_data_o = 0xFFFF_FF80, wb_valid_o exactly at R+1.
- **SH upper half:** SH at 0x2002, wdata 0x0000_BEEF → bus_addr_o = 0x2000, be = 4'b1100, bus_wdata_o = 0xBEEF_0000. store_done_o follows rvalid.
- **Misaligned:** LW at 0x3001 → no bus_req_o, misaligned_o pulse, bad_addr_o = 0x3001.
- **Outstanding limit:** OUTSTANDING=2, gnt held 1, rvalid delayed 5 cycles, 4 back-to-back LW with distinct rd → exactly 2 grants before the first rvalid, writebacks in request order with correct rd.
- **Flush:** flush_i one cycle after two loads are granted → both rvalids consumed, wb_valid_o stays 0, cnt returns to 0, busy_o drops.
- **XLEN=64 and reset:** LWU at offset 4, rdata 0x8000_0001_xxxx_xxxx → wb_data_o = 0x0000_0000_8000_0001. rst asserted with 2 pending, then rvalid → spurious_o pulse, no wb_valid_o.

Source files
------------

// File: rtl/exu_lsu_pipe_if.sv
// Execute-side request, core data bus and writeback signals of the load/store unit.
// slave is the LSU view; master is the environment (dispatch, bus and writeback side).
interface exu_lsu_pipe_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RD_W   = 5
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [ADDR_W-1:0]   req_addr_i;
  logic [XLEN-1:0]     req_wdata_i;
  logic                req_we_i;
  logic [1:0]          req_size_i;
  logic                req_unsigned_i;
  logic [RD_W-1:0]     req_rd_i;
  logic                flush_i;

  logic                bus_req_o;
  logic                bus_gnt_i;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic                bus_we_o;
  logic [XLEN/8-1:0]   bus_be_o;
  logic [XLEN-1:0]     bus_wdata_o;
  logic                bus_rvalid_i;
  logic [XLEN-1:0]     bus_rdata_i;

  logic                wb_valid_o;
  logic [RD_W-1:0]     wb_rd_o;
  logic [XLEN-1:0]     wb_data_o;
  logic                store_done_o;
  logic                misaligned_o;
  logic [ADDR_W-1:0]   bad_addr_o;
  logic                spurious_o;
  logic                busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_size_i,
           req_unsigned_i, req_rd_i, flush_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    output req_ready_o, bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, store_done_o, misaligned_o, bad_addr_o,
           spurious_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_size_i,
           req_unsigned_i, req_rd_i, flush_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i,
    input  req_ready_o, bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, store_done_o, misaligned_o, bad_addr_o,
           spurious_o, busy_o
  );
endinterface

// File: rtl/exu_lsu_pipe.sv
// Pipelined load/store unit: registered issue stage, in-order pending FIFO of
// granted transactions, flush-kill of in-flight loads and registered writeback.
module exu_lsu_pipe #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned RD_W        = 5
) (
  input  logic           clk,
  input  logic           rst,
  exu_lsu_pipe_if.slave  io
);
  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(BE_W);
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);

  typedef struct packed {
    logic             we;
    logic [RD_W-1:0]  rd;
    logic [1:0]       size;
    logic [OFF_W-1:0] off;
    logic             uns;
    logic             kill;
  } meta_t;

  // Issue register
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_we;
  logic [BE_W-1:0]   iss_be;
  logic [XLEN-1:0]   iss_wdata;
  logic [RD_W-1:0]   iss_rd;
  logic [1:0]        iss_size;
  logic [OFF_W-1:0]  iss_off;
  logic              iss_uns;

  // Pending FIFO of granted, unanswered transactions
  meta_t             meta_q [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  logic              bus_req;
  logic              grant;
  logic              ready;
  logic              accept;
  logic              pop;
  logic [OFF_W-1:0]  off;
  logic [2:0]        size_mask;
  logic [7:0]        be_base;
  logic              misaligned;
  meta_t             head;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   keep;
  logic              sgn;
  logic [XLEN-1:0]   ld_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (OUTSTANDING == 1) ? '0 : p + 1'b1;
  endfunction

  // Grant limit uses the pre-pop count, so a same-cycle response never frees a slot early
  assign bus_req = ~rst & iss_valid & (cnt < CNT_W'(OUTSTANDING));
  assign grant   = bus_req & io.bus_gnt_i;
  assign ready   = ~rst & ~io.flush_i & (~iss_valid | grant);
  assign accept  = io.req_valid_i & ready;
  assign pop     = io.bus_rvalid_i & (cnt != '0);

  assign io.req_ready_o = ready;
  assign io.bus_req_o   = bus_req;
  assign io.bus_addr_o  = iss_addr;
  assign io.bus_we_o    = iss_we;
  assign io.bus_be_o    = iss_be;
  assign io.bus_wdata_o = iss_wdata;
  assign io.busy_o      = ~rst & (iss_valid | (cnt != '0));

  // Request decode: lane offset, alignment check and byte-enable base pattern
  always_comb begin
    off       = io.req_addr_i[OFF_W-1:0];
    size_mask = 3'd0;
    be_base   = 8'h00;
    case (io.req_size_i)
      2'd0:    begin size_mask = 3'd0; be_base = 8'h01; end
      2'd1:    begin size_mask = 3'd1; be_base = 8'h03; end
      2'd2:    begin size_mask = 3'd3; be_base = 8'h0F; end
      default: begin size_mask = 3'd7; be_base = 8'hFF; end
    endcase
    misaligned = (|(3'(off) & size_mask)) | ((io.req_size_i == 2'd3) && (XLEN == 32));
  end

  // Load formatting of the response for the FIFO head
  always_comb begin
    head    = meta_q[rd_ptr];
    shifted = io.bus_rdata_i >> {head.off, 3'b000};
    keep    = '1;
    sgn     = shifted[XLEN-1];
    case (head.size)
      2'd0:    begin keep = XLEN'(64'hFF);        sgn = shifted[7];  end
      2'd1:    begin keep = XLEN'(64'hFFFF);      sgn = shifted[15]; end
      2'd2:    begin keep = XLEN'(64'hFFFF_FFFF); sgn = shifted[31]; end
      default: begin keep = '1;                   sgn = shifted[XLEN-1]; end
    endcase
    ld_data = (shifted & keep) | ({XLEN{sgn & ~head.uns}} & ~keep);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid       <= 1'b0;
      iss_addr        <= '0;
      iss_we          <= 1'b0;
      iss_be          <= '0;
      iss_wdata       <= '0;
      iss_rd          <= '0;
      iss_size        <= '0;
      iss_off         <= '0;
      iss_uns         <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) meta_q[i] <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      cnt             <= '0;
      io.wb_valid_o   <= 1'b0;
      io.wb_rd_o      <= '0;
      io.wb_data_o    <= '0;
      io.store_done_o <= 1'b0;
      io.misaligned_o <= 1'b0;
      io.bad_addr_o   <= '0;
      io.spurious_o   <= 1'b0;
    end else begin
      if (accept && !misaligned) begin
        iss_valid <= 1'b1;
        iss_addr  <= {io.req_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
        iss_we    <= io.req_we_i;
        iss_be    <= BE_W'(be_base) << off;
        iss_wdata <= io.req_wdata_i << {off, 3'b000};
        iss_rd    <= io.req_rd_i;
        iss_size  <= io.req_size_i;
        iss_off   <= off;
        iss_uns   <= io.req_unsigned_i;
      end else if (grant || io.flush_i) begin
        iss_valid <= 1'b0;
      end

      // Flush marks every pending entry; a same-cycle grant still pushes, already killed
      if (io.flush_i) begin
        for (int i = 0; i < OUTSTANDING; i++) meta_q[i].kill <= 1'b1;
      end
      if (grant) begin
        meta_q[wr_ptr] <= '{we: iss_we, rd: iss_rd, size: iss_size, off: iss_off,
                            uns: iss_uns, kill: io.flush_i};
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({grant, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      io.wb_valid_o   <= pop & ~head.we & ~head.kill & ~io.flush_i;
      io.store_done_o <= pop & head.we;
      if (pop && !head.we) begin
        io.wb_rd_o   <= head.rd;
        io.wb_data_o <= ld_data;
      end

      io.misaligned_o <= accept & misaligned;
      if (accept && misaligned) io.bad_addr_o <= io.req_addr_i;
      io.spurious_o <= io.bus_rvalid_i & (cnt == '0);
    end
  end
endmodule

// File: tb/tb_exu_lsu_pipe.sv
// Directed bench for exu_lsu_pipe: one XLEN=32 and one XLEN=64 instance on a shared clock/reset.
module tb_exu_lsu_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  exu_lsu_pipe_if #(.ADDR_W(32), .XLEN(32), .RD_W(5)) i32 ();
  exu_lsu_pipe_if #(.ADDR_W(32), .XLEN(64), .RD_W(5)) i64 ();

  exu_lsu_pipe #(.ADDR_W(32), .XLEN(32), .OUTSTANDING(2), .RD_W(5)) u32 (
    .clk(clk), .rst(rst), .io(i32.slave));
  exu_lsu_pipe #(.ADDR_W(32), .XLEN(64), .OUTSTANDING(2), .RD_W(5)) u64 (
    .clk(clk), .rst(rst), .io(i64.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i32.req_valid_i = 0; i32.req_addr_i = '0; i32.req_wdata_i = '0; i32.req_we_i = 0;
    i32.req_size_i = '0; i32.req_unsigned_i = 0; i32.req_rd_i = '0; i32.flush_i = 0;
    i32.bus_gnt_i = 0; i32.bus_rvalid_i = 0; i32.bus_rdata_i = '0;
    i64.req_valid_i = 0; i64.req_addr_i = '0; i64.req_wdata_i = '0; i64.req_we_i = 0;
    i64.req_size_i = '0; i64.req_unsigned_i = 0; i64.req_rd_i = '0; i64.flush_i = 0;
    i64.bus_gnt_i = 0; i64.bus_rvalid_i = 0; i64.bus_rdata_i = '0;
  endtask

  task automatic req32(input logic v, input logic [31:0] a, input logic [1:0] sz,
                       input logic we, input logic [31:0] wd, input logic [4:0] rd);
    i32.req_valid_i = v; i32.req_addr_i = a; i32.req_size_i = sz; i32.req_we_i = we;
    i32.req_wdata_i = wd; i32.req_rd_i = rd; i32.req_unsigned_i = 0;
  endtask

  task automatic req64(input logic v, input logic [31:0] a, input logic [1:0] sz,
                       input logic uns, input logic [4:0] rd);
    i64.req_valid_i = v; i64.req_addr_i = a; i64.req_size_i = sz; i64.req_we_i = 0;
    i64.req_wdata_i = '0; i64.req_rd_i = rd; i64.req_unsigned_i = uns;
  endtask

  int          q_due[$];
  int          nreq;
  int          nresp;
  int          grants_early;
  logic        seen_rv;
  logic        wb_exp;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        rv;

  initial begin
    idle();
    rst = 1;
    step(); step();
    check("rst_ready", i32.req_ready_o, 0);
    check("rst_busreq", i32.bus_req_o, 0);
    check("rst_busy", i32.busy_o, 0);
    check("rst_wb", i32.wb_valid_o, 0);
    check("rst_mis", i32.misaligned_o, 0);
    check("rst_spur", i64.spurious_o, 0);
    check("rst_wbdata", i64.wb_data_o, 0);
    rst = 0;
    step();
    check("ready_after_rst", i32.req_ready_o, 1);

    // LB at 0x1003, sign-extended
    req32(1, 32'h1003, 2'd0, 0, 0, 5'd5); #1;
    check("lb_ready", i32.req_ready_o, 1);
    step();
    req32(0, 0, 0, 0, 0, 0); i32.bus_gnt_i = 1; #1;
    check("lb_busreq", i32.bus_req_o, 1);
    check("lb_addr", i32.bus_addr_o, 32'h1000);
    check("lb_be", i32.bus_be_o, 4'b1000);
    check("lb_we", i32.bus_we_o, 0);
    step();
    i32.bus_gnt_i = 0; i32.bus_rvalid_i = 1; i32.bus_rdata_i = 32'h80FF_0000; #1;
    check("lb_wb_early", i32.wb_valid_o, 0);
    step();
    i32.bus_rvalid_i = 0; #1;
    check("lb_wb", i32.wb_valid_o, 1);
    check("lb_data", i32.wb_data_o, 32'hFFFF_FF80);
    check("lb_rd", i32.wb_rd_o, 5);
    step();
    check("lb_wb_pulse", i32.wb_valid_o, 0);
    check("lb_busy", i32.busy_o, 0);

    // SH at 0x2002, held one cycle without grant
    req32(1, 32'h2002, 2'd1, 1, 32'h0000_BEEF, 0);
    step();
    req32(0, 0, 0, 0, 0, 0); #1;
    check("sh_busreq", i32.bus_req_o, 1);
    check("sh_addr", i32.bus_addr_o, 32'h2000);
    check("sh_be", i32.bus_be_o, 4'b1100);
    check("sh_wdata", i32.bus_wdata_o, 32'hBEEF_0000);
    check("sh_we", i32.bus_we_o, 1);
    step();
    i32.bus_gnt_i = 1; #1;
    check("sh_hold_addr", i32.bus_addr_o, 32'h2000);
    check("sh_hold_wdata", i32.bus_wdata_o, 32'hBEEF_0000);
    step();
    i32.bus_gnt_i = 0; i32.bus_rvalid_i = 1; i32.bus_rdata_i = '0; #1;
    check("sh_done_early", i32.store_done_o, 0);
    step();
    i32.bus_rvalid_i = 0; #1;
    check("sh_done", i32.store_done_o, 1);
    check("sh_no_wb", i32.wb_valid_o, 0);
    step();
    check("sh_done_pulse", i32.store_done_o, 0);

    // Misaligned LW at 0x3001
    req32(1, 32'h3001, 2'd2, 0, 0, 5'd1); #1;
    check("mis_ready", i32.req_ready_o, 1);
    step();
    req32(0, 0, 0, 0, 0, 0); #1;
    check("mis_busreq", i32.bus_req_o, 0);
    check("mis_pulse", i32.misaligned_o, 1);
    check("mis_addr", i32.bad_addr_o, 32'h3001);
    check("mis_busy", i32.busy_o, 0);
    step();
    check("mis_pulse_end", i32.misaligned_o, 0);

    // Four back-to-back LW, gnt held, responses 5 cycles after grant
    nreq = 0; nresp = 0; grants_early = 0; seen_rv = 0; wb_exp = 0;
    exp_rd = '0; exp_data = '0;
    for (int c = 0; c < 20; c++) begin
      req32(nreq < 4, 32'h40 + 32'(4 * nreq), 2'd2, 0, 0, 5'(nreq + 1));
      i32.bus_gnt_i = 1;
      rv = (q_due.size() > 0) && (q_due[0] == c);
      i32.bus_rvalid_i = rv;
      i32.bus_rdata_i = 32'hA000_0000 + 32'(nresp);
      #1;
      if (wb_exp) begin
        check("ost_wb", i32.wb_valid_o, 1);
        check("ost_rd", i32.wb_rd_o, exp_rd);
        check("ost_data", i32.wb_data_o, exp_data);
      end else begin
        check("ost_wb_idle", i32.wb_valid_o, 0);
      end
      if (rv) seen_rv = 1;
      if (i32.bus_req_o && i32.bus_gnt_i) begin
        q_due.push_back(c + 5);
        if (!seen_rv) grants_early++;
      end
      if (i32.req_valid_i && i32.req_ready_o) nreq++;
      wb_exp = rv;
      if (rv) begin
        exp_rd = 5'(nresp + 1);
        exp_data = 32'hA000_0000 + 32'(nresp);
        void'(q_due.pop_front());
        nresp++;
      end
      step();
    end
    req32(0, 0, 0, 0, 0, 0); i32.bus_gnt_i = 0; i32.bus_rvalid_i = 0; #1;
    check("ost_grants_before_rv", 64'(grants_early), 2);
    check("ost_responses", 64'(nresp), 4);
    check("ost_busy", i32.busy_o, 0);

    // Flush one cycle after two loads are granted
    req32(1, 32'h50, 2'd2, 0, 0, 5'd9);
    step();
    req32(1, 32'h54, 2'd2, 0, 0, 5'd10); i32.bus_gnt_i = 1; #1;
    check("fl_ready_on_gnt", i32.req_ready_o, 1);
    step();
    req32(0, 0, 0, 0, 0, 0); #1;
    check("fl_busreq2", i32.bus_req_o, 1);
    step();
    i32.bus_gnt_i = 0; i32.flush_i = 1; req32(1, 32'h58, 2'd2, 0, 0, 5'd11); #1;
    check("fl_ready_blocked", i32.req_ready_o, 0);
    check("fl_busy", i32.busy_o, 1);
    step();
    i32.flush_i = 0; req32(0, 0, 0, 0, 0, 0);
    i32.bus_rvalid_i = 1; i32.bus_rdata_i = 32'h1234_5678;
    step();
    #1;
    check("fl_wb0", i32.wb_valid_o, 0);
    step();
    i32.bus_rvalid_i = 0; #1;
    check("fl_wb1", i32.wb_valid_o, 0);
    check("fl_busy_end", i32.busy_o, 0);
    check("fl_spur", i32.spurious_o, 0);

    // Flush drops an ungranted issue register
    req32(1, 32'h60, 2'd2, 0, 0, 5'd3);
    step();
    req32(0, 0, 0, 0, 0, 0); i32.flush_i = 1; #1;
    check("fl_iss_busreq", i32.bus_req_o, 1);
    step();
    i32.flush_i = 0; #1;
    check("fl_iss_dropped", i32.bus_req_o, 0);
    check("fl_iss_busy", i32.busy_o, 0);

    // Grant and flush in the same cycle: pushed killed
    req32(1, 32'h64, 2'd2, 0, 0, 5'd4);
    step();
    req32(0, 0, 0, 0, 0, 0); i32.flush_i = 1; i32.bus_gnt_i = 1; #1;
    check("fg_busreq", i32.bus_req_o, 1);
    step();
    i32.flush_i = 0; i32.bus_gnt_i = 0; #1;
    check("fg_pending", i32.busy_o, 1);
    i32.bus_rvalid_i = 1; i32.bus_rdata_i = 32'hCAFE_F00D;
    step();
    i32.bus_rvalid_i = 0; #1;
    check("fg_wb", i32.wb_valid_o, 0);
    check("fg_busy", i32.busy_o, 0);
    check("fg_spur", i32.spurious_o, 0);

    // XLEN=64: LWU at offset 4
    req64(1, 32'h104, 2'd2, 1, 5'd6);
    step();
    req64(0, 0, 0, 0, 0); i64.bus_gnt_i = 1; #1;
    check("w64_addr", i64.bus_addr_o, 32'h100);
    check("w64_be", i64.bus_be_o, 8'hF0);
    step();
    i64.bus_gnt_i = 0; i64.bus_rvalid_i = 1; i64.bus_rdata_i = 64'h8000_0001_DEAD_BEEF;
    step();
    i64.bus_rvalid_i = 0; #1;
    check("lwu_wb", i64.wb_valid_o, 1);
    check("lwu_data", i64.wb_data_o, 64'h0000_0000_8000_0001);
    check("lwu_rd", i64.wb_rd_o, 6);

    // XLEN=64: signed LW at offset 4
    req64(1, 32'h104, 2'd2, 0, 5'd7);
    step();
    req64(0, 0, 0, 0, 0); i64.bus_gnt_i = 1;
    step();
    i64.bus_gnt_i = 0; i64.bus_rvalid_i = 1; i64.bus_rdata_i = 64'h8000_0001_DEAD_BEEF;
    step();
    i64.bus_rvalid_i = 0; #1;
    check("lw64_data", i64.wb_data_o, 64'hFFFF_FFFF_8000_0001);

    // XLEN=64: LD aligned
    req64(1, 32'h108, 2'd3, 0, 5'd8);
    step();
    req64(0, 0, 0, 0, 0); i64.bus_gnt_i = 1; #1;
    check("ld_addr", i64.bus_addr_o, 32'h108);
    check("ld_be", i64.bus_be_o, 8'hFF);
    step();
    i64.bus_gnt_i = 0; i64.bus_rvalid_i = 1; i64.bus_rdata_i = 64'h0123_4567_89AB_CDEF;
    step();
    i64.bus_rvalid_i = 0; #1;
    check("ld_data", i64.wb_data_o, 64'h0123_4567_89AB_CDEF);
    check("ld_mis", i64.misaligned_o, 0);

    // Reset with two pending, then a stray response
    req64(1, 32'h200, 2'd3, 0, 5'd1);
    step();
    req64(1, 32'h208, 2'd3, 0, 5'd2); i64.bus_gnt_i = 1;
    step();
    req64(0, 0, 0, 0, 0);
    step();
    i64.bus_gnt_i = 0; rst = 1; #1;
    check("mrst_busreq", i64.bus_req_o, 0);
    check("mrst_busy", i64.busy_o, 0);
    check("mrst_ready", i64.req_ready_o, 0);
    step();
    rst = 0; #1;
    check("mrst_busy_after", i64.busy_o, 0);
    check("mrst_wb", i64.wb_valid_o, 0);
    i64.bus_rvalid_i = 1; i64.bus_rdata_i = 64'h1111_2222_3333_4444;
    step();
    i64.bus_rvalid_i = 0; #1;
    check("mrst_spur", i64.spurious_o, 1);
    check("mrst_no_wb", i64.wb_valid_o, 0);
    step();
    check("mrst_spur_pulse", i64.spurious_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
